// File: rtl/sd_read_sector.sv
// sd_read_sector: SPI-mode single-sector read engine for an SD card.
// Sends CMD17, waits for R1 and the 0xFE start token, then streams the
// 512-byte payload as 256 16-bit words and discards the CRC.
module sd_read_sector #(
  parameter int CLK_DIV         = 100,  // sd_clk half-period in clk_ref cycles, >= 2
  parameter int R1_MAX_BYTES    = 8,
  parameter int TOKEN_MAX_BYTES = 4096
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        rd_start,
  input  logic [31:0] rd_sec_addr,
  input  logic        sd_miso,
  output logic        sd_clk,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic        rd_busy,
  output logic        rd_val_en,
  output logic [15:0] rd_val_data,
  output logic        rd_done,
  output logic [1:0]  rd_err
);

  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND_CMD, ST_WAIT_R1, ST_WAIT_TOKEN,
    ST_READ_DATA, ST_READ_CRC, ST_TRAIL, ST_DONE
  } state_t;

  state_t            r_state, w_state_next;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_sd_clk, r_sd_cs, r_busy, r_val_en, r_done;
  logic [15:0]       r_val_data;
  logic [1:0]        r_err;
  logic [47:0]       r_cmd;
  logic [15:0]       r_shift;
  logic [11:0]       r_bit_cnt;    // sampled bits in the current state
  logic [BYTE_W-1:0] r_byte_cnt;   // polled bytes in the current state

  logic              w_running, w_tick, w_rise, w_fall, w_accept, w_byte_end;
  logic [15:0]       w_shift_next;
  logic [7:0]        w_byte;
  logic              w_err_set;
  logic [1:0]        w_err_code;

  // SPI clock-edge strobes, request acceptance and the byte just assembled.
  // NOTE: every signal written here gets a value before any branch, so no path can infer a latch.
  always_comb begin
    w_running    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    w_tick       = w_running && (r_div_cnt == DIV_W'(CLK_DIV - 1));
    w_rise       = w_tick && !r_sd_clk;
    w_fall       = w_tick && r_sd_clk;
    w_accept     = (r_state == ST_IDLE) && rd_start && sd_init_done;
    w_shift_next = {r_shift[14:0], sd_miso};
    w_byte       = w_shift_next[7:0];
    w_byte_end   = (r_bit_cnt[2:0] == 3'd7);
  end

  // Next-state and error-code decode; transitions happen on sd_clk edges.
  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    w_err_code   = 2'd0;
    unique case (r_state)
      ST_IDLE:      if (w_accept) w_state_next = ST_SEND_CMD;
      ST_SEND_CMD:  if (w_rise && r_bit_cnt == 12'd47) w_state_next = ST_WAIT_R1;
      ST_WAIT_R1: begin
        if (w_rise && w_byte_end) begin
          if (!w_byte[7]) begin
            if (w_byte == 8'h00) begin
              w_state_next = ST_WAIT_TOKEN;
            end else begin
              w_state_next = ST_TRAIL;
              w_err_set    = 1'b1;
              w_err_code   = 2'd2;
            end
          end else if (r_byte_cnt == BYTE_W'(R1_MAX_BYTES - 1)) begin
            w_state_next = ST_TRAIL;
            w_err_set    = 1'b1;
            w_err_code   = 2'd1;
          end
        end
      end
      ST_WAIT_TOKEN: begin
        if (w_rise && w_byte_end) begin
          if (w_byte == 8'hFE) begin
            w_state_next = ST_READ_DATA;
          end else if (w_byte != 8'hFF || r_byte_cnt == BYTE_W'(TOKEN_MAX_BYTES - 1)) begin
            w_state_next = ST_TRAIL;
            w_err_set    = 1'b1;
            w_err_code   = 2'd3;
          end
        end
      end
      ST_READ_DATA: if (w_rise && r_bit_cnt == 12'd4095) w_state_next = ST_READ_CRC;
      ST_READ_CRC:  if (w_rise && r_bit_cnt == 12'd15) w_state_next = ST_TRAIL;
      // Leave on a falling edge so sd_clk is already low when DONE is reached.
      ST_TRAIL:     if (w_fall && r_bit_cnt == 12'd8) w_state_next = ST_DONE;
      ST_DONE:      w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_ref) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // SPI datapath, counters and host-side outputs.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_sd_clk   <= 1'b0;
      r_sd_cs    <= 1'b1;
      r_busy     <= 1'b0;
      r_val_en   <= 1'b0;
      r_val_data <= '0;
      r_done     <= 1'b0;
      r_err      <= 2'd0;
      r_cmd      <= '1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_div_cnt <= (!w_running || w_tick) ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) r_sd_clk <= ~r_sd_clk;

      if (w_accept)                        r_sd_cs <= 1'b0;
      else if (w_state_next == ST_TRAIL)   r_sd_cs <= 1'b1;

      // The command register doubles as the latched sector address.
      if (w_accept)                             r_cmd <= {8'h51, rd_sec_addr, 8'hFF};
      else if (r_state == ST_SEND_CMD && w_fall) r_cmd <= {r_cmd[46:0], 1'b1};

      if (w_rise) r_shift <= w_shift_next;

      if (w_state_next != r_state) begin
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 12'd1;
        if (w_byte_end) r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
      end

      r_val_en <= 1'b0;
      if (r_state == ST_READ_DATA && w_rise && r_bit_cnt[3:0] == 4'hF) begin
        r_val_en   <= 1'b1;
        r_val_data <= w_shift_next;
      end

      if (w_accept)       r_err <= 2'd0;
      else if (w_err_set) r_err <= w_err_code;

      r_busy <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
      r_done <= (w_state_next == ST_DONE);
    end
  end

  assign sd_clk      = r_sd_clk;
  assign sd_cs       = r_sd_cs;
  assign sd_mosi     = (r_state == ST_SEND_CMD) ? r_cmd[47] : 1'b1;
  assign rd_busy     = r_busy;
  assign rd_val_en   = r_val_en;
  assign rd_val_data = r_val_data;
  assign rd_done     = r_done;
  assign rd_err      = r_err;

endmodule

// File: tb/tb_sd_read_sector.sv
// tb_sd_read_sector: directed bench with an SD card model on the SPI pins and
// a scoreboard of expected payload words consumed by a separate monitor.
module tb_sd_read_sector;

  localparam int CLK_DIV = 2;
  localparam int BUDGET  = 30000;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        sd_init_done = 1'b0;
  logic        rd_start = 1'b0;
  logic [31:0] rd_sec_addr = '0;
  logic        sd_miso = 1'b1;
  logic        sd_clk, sd_cs, sd_mosi, rd_busy, rd_val_en, rd_done;
  logic [15:0] rd_val_data;
  logic [1:0]  rd_err;

  sd_read_sector #(.CLK_DIV(CLK_DIV), .R1_MAX_BYTES(8), .TOKEN_MAX_BYTES(4096)) dut (
    .clk_ref(clk_ref), .rst(rst), .sd_init_done(sd_init_done), .rd_start(rd_start),
    .rd_sec_addr(rd_sec_addr), .sd_miso(sd_miso), .sd_clk(sd_clk), .sd_cs(sd_cs),
    .sd_mosi(sd_mosi), .rd_busy(rd_busy), .rd_val_en(rd_val_en),
    .rd_val_data(rd_val_data), .rd_done(rd_done), .rd_err(rd_err)
  );

  always #5 clk_ref = ~clk_ref;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- card model ----------------
  logic       cfg_r1_en = 1'b1;
  int         cfg_r1_idle = 0;
  logic [7:0] cfg_r1 = 8'h00;
  int         cfg_tok_idle = 0;
  logic [7:0] cfg_tok = 8'hFE;
  int         cfg_seed = 0;

  // Byte k of the card's reply stream after the 48-bit command.
  function automatic logic [7:0] card_byte(input int k);
    int i;
    i = k;
    if (!cfg_r1_en) return 8'hFF;
    if (i < cfg_r1_idle) return 8'hFF;
    i -= cfg_r1_idle;
    if (i == 0) return cfg_r1;
    i--;
    if (i < cfg_tok_idle) return 8'hFF;
    i -= cfg_tok_idle;
    if (i == 0) return cfg_tok;
    i--;
    if (i < 512) return 8'((i + cfg_seed) & 255);
    if (i < 514) return 8'h3C;
    return 8'hFF;
  endfunction

  int          c_bits = 0, c_k = 0, c_bit = 0;
  logic        c_prev_clk = 1'b0;
  logic [47:0] c_cmd = '0;
  logic [7:0]  c_cur = 8'hFF;

  // Card: captures MOSI on sd_clk rise, shifts MISO on sd_clk fall (mode 0).
  always @(negedge clk_ref) begin
    if (sd_cs !== 1'b0) begin
      c_bits = 0; c_k = 0; c_bit = 0; sd_miso = 1'b1;
    end else if (sd_clk && !c_prev_clk) begin
      if (c_bits < 48) begin
        c_cmd = {c_cmd[46:0], sd_mosi};
        c_bits++;
      end
    end else if (!sd_clk && c_prev_clk && c_bits >= 48) begin
      if (c_bit == 0) c_cur = card_byte(c_k);
      sd_miso = c_cur[3'(7 - c_bit)];
      c_bit++;
      if (c_bit == 8) begin c_bit = 0; c_k++; end
    end
    c_prev_clk = sd_clk;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] exp_q[$];
  int          sb_rd = 0;
  int          n_strobe = 0, n_done = 0, n_trail = 0;
  logic [1:0]  done_err = '0;
  logic        done_cs = 1'b0;
  logic        m_prev_clk = 1'b0, m_prev_cs = 1'b1;

  always @(negedge clk_ref) begin
    if (rd_val_en === 1'b1) begin
      n_strobe++;
      if (sb_rd < exp_q.size()) begin
        check($sformatf("payload word %0d", sb_rd), rd_val_data, exp_q[sb_rd]);
        sb_rd++;
      end else begin
        check("strobe beyond expected words", sb_rd, exp_q.size());
      end
    end
    if (rd_done === 1'b1) begin
      n_done++;
      done_err = rd_err;
      done_cs  = sd_cs;
      check("rd_busy low with rd_done", rd_busy, 1'b0);
    end
    if (sd_clk && !m_prev_clk && sd_cs && m_prev_cs) n_trail++;
    m_prev_clk = sd_clk;
    m_prev_cs  = sd_cs;
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] exp_word(input int seed, input int j);
    return {8'((2 * j + seed) & 255), 8'((2 * j + 1 + seed) & 255)};
  endfunction

  task automatic push_words(input int seed, input int count);
    for (int j = 0; j < count; j++) exp_q.push_back(exp_word(seed, j));
  endtask

  task automatic start_read(input logic [31:0] addr);
    @(negedge clk_ref);
    rd_sec_addr = addr;
    rd_start    = 1'b1;
    @(negedge clk_ref);
    rd_start    = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int cyc = 0;
    while (n_done == base && cyc < BUDGET) begin
      @(negedge clk_ref); #1; cyc++;
    end
    check("rd_done within budget", n_done != base, 1'b1);
  endtask

  task automatic wait_strobes(input int target);
    int cyc = 0;
    while (n_strobe < target && cyc < BUDGET) begin
      @(negedge clk_ref); #1; cyc++;
    end
    check("strobes within budget", n_strobe >= target, 1'b1);
  endtask

  initial begin
    int   base_s, base_d, base_t;
    logic seen_busy, seen_cs_low;

    // Reset values while rst is held.
    repeat (3) @(negedge clk_ref);
    check("reset sd_clk", sd_clk, 1'b0);
    check("reset sd_cs", sd_cs, 1'b1);
    check("reset sd_mosi", sd_mosi, 1'b1);
    check("reset rd_busy", rd_busy, 1'b0);
    check("reset rd_val_en", rd_val_en, 1'b0);
    check("reset rd_val_data", rd_val_data, 16'h0000);
    check("reset rd_done", rd_done, 1'b0);
    check("reset rd_err", rd_err, 2'd0);
    rst = 1'b0;

    // Start while the card is not initialised is ignored.
    base_d = n_done;
    start_read(32'h0000_0001);
    seen_busy = 1'b0; seen_cs_low = 1'b0;
    repeat (20) begin
      @(negedge clk_ref);
      if (rd_busy !== 1'b0) seen_busy = 1'b1;
      if (sd_cs !== 1'b1) seen_cs_low = 1'b1;
    end
    check("gated: rd_busy seen", seen_busy, 1'b0);
    check("gated: sd_cs low seen", seen_cs_low, 1'b0);
    check("gated: rd_done count", n_done - base_d, 0);
    sd_init_done = 1'b1;

    // Nominal read with a second start issued mid-payload.
    cfg_r1_en = 1'b1; cfg_r1_idle = 2; cfg_r1 = 8'h00;
    cfg_tok_idle = 10; cfg_tok = 8'hFE; cfg_seed = 0;
    push_words(0, 256);
    base_s = n_strobe; base_d = n_done; base_t = n_trail;
    start_read(32'h0000_1234);
    check("nominal: rd_busy after accept", rd_busy, 1'b1);
    wait_strobes(base_s + 50);
    rd_sec_addr = 32'hFFFF_0000;
    rd_start    = 1'b1;
    @(negedge clk_ref);
    rd_start    = 1'b0;
    check("nominal: busy after ignored start", rd_busy, 1'b1);
    wait_done(base_d);
    check("nominal: mosi command", c_cmd, 48'h51_0000_1234_FF);
    check("nominal: strobe count", n_strobe - base_s, 256);
    check("nominal: rd_err", done_err, 2'd0);
    check("nominal: sd_cs at done", done_cs, 1'b1);
    check("nominal: trail sd_clk cycles", n_trail - base_t, 8);
    check("nominal: words consumed", sb_rd, exp_q.size());
    seen_busy = 1'b0;
    repeat (10) begin
      @(negedge clk_ref);
      if (rd_busy !== 1'b0) seen_busy = 1'b1;
    end
    check("nominal: no restart from ignored start", seen_busy, 1'b0);
    check("nominal: rd_done pulse count", n_done - base_d, 1);
    check("nominal: rd_val_data held", rd_val_data, 16'hFEFF);
    check("nominal: sd_clk idle", sd_clk, 1'b0);

    // R1 timeout: MISO stuck high.
    cfg_r1_en = 1'b0;
    base_s = n_strobe; base_d = n_done;
    start_read(32'h0000_0010);
    wait_done(base_d);
    check("r1 timeout: rd_err", done_err, 2'd1);
    check("r1 timeout: strobes", n_strobe - base_s, 0);
    check("r1 timeout: rd_err held", rd_err, 2'd1);

    // R1 nonzero.
    cfg_r1_en = 1'b1; cfg_r1_idle = 1; cfg_r1 = 8'h04;
    base_s = n_strobe; base_d = n_done;
    start_read(32'h0000_0020);
    wait_done(base_d);
    check("r1 error: rd_err", done_err, 2'd2);
    check("r1 error: strobes", n_strobe - base_s, 0);
    check("r1 error: sd_cs at done", done_cs, 1'b1);

    // Data-error token.
    cfg_r1_idle = 0; cfg_r1 = 8'h00; cfg_tok_idle = 3; cfg_tok = 8'h08;
    base_s = n_strobe; base_d = n_done;
    start_read(32'h0000_0030);
    wait_done(base_d);
    check("token error: rd_err", done_err, 2'd3);
    check("token error: strobes", n_strobe - base_s, 0);

    // Clean restart clears rd_err; reset lands after strobe 100.
    cfg_r1_idle = 1; cfg_tok_idle = 2; cfg_tok = 8'hFE; cfg_seed = 8'h80;
    push_words(8'h80, 100);
    base_s = n_strobe; base_d = n_done;
    start_read(32'hDEAD_BEEF);
    check("restart: rd_err cleared", rd_err, 2'd0);
    wait_strobes(base_s + 100);
    rst = 1'b1;
    @(posedge clk_ref); #1;
    check("mid reset: sd_cs", sd_cs, 1'b1);
    check("mid reset: sd_clk", sd_clk, 1'b0);
    check("mid reset: rd_busy", rd_busy, 1'b0);
    check("mid reset: rd_done", rd_done, 1'b0);
    check("mid reset: rd_val_data", rd_val_data, 16'h0000);
    repeat (3) @(negedge clk_ref);
    rst = 1'b0;
    repeat (5) @(negedge clk_ref);
    check("mid reset: no rd_done", n_done - base_d, 0);
    check("mid reset: mosi command", c_cmd, 48'h51_DEAD_BEEF_FF);
    check("mid reset: words consumed", sb_rd, exp_q.size());

    // Fresh read after reset.
    cfg_r1_idle = 0; cfg_tok_idle = 0; cfg_seed = 8'h37;
    push_words(8'h37, 256);
    base_s = n_strobe; base_d = n_done;
    start_read(32'h0000_0042);
    wait_done(base_d);
    check("fresh: mosi command", c_cmd, 48'h51_0000_0042_FF);
    check("fresh: strobe count", n_strobe - base_s, 256);
    check("fresh: rd_err", done_err, 2'd0);
    check("fresh: words consumed", sb_rd, exp_q.size());
    check("fresh: last word held", rd_val_data, 16'h3536);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_read_sector.md
Name: sd_read_sector

Overview:
- Single-sector SPI-mode read engine placed directly downstream of the SD card initialisation stage.
- Once sd_init_done is high, it accepts a sector address and issues CMD17 to the card.
- It waits for the R1 response and the data start token, then streams the 512-byte payload out as 256 16-bit words.
- It discards the CRC and releases the bus.
- It drives its own sd_clk/sd_cs/sd_mosi; top-level muxing hands it the SPI pins after init completes.

Parameters:
- CLK_DIV, 100: sd_clk half-period in clk_ref cycles (50 MHz / 200 = 250 kHz default); must be ≥ 2.
- R1_MAX_BYTES, 8: number of byte slots polled for R1 before timeout.
- TOKEN_MAX_BYTES, 4096: number of byte slots polled for the 0xFE start token before timeout.

Ports:
- clk_ref  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset: synchronous, active-high.
- sd_init_done  input  1  card initialised; level signal.
- rd_start  input  1  one-cycle request pulse.
- rd_sec_addr  input  32  sector (block) address, sampled on an accepted rd_start.
- sd_miso  input  1  card data out.
- sd_clk  output  1  SPI clock; idles low.
- sd_cs  output  1  chip select, active-low.
- sd_mosi  output  1  host data out.
- rd_busy  output  1  high from acceptance until rd_done.
- rd_val_en  output  1  one-cycle strobe; rd_val_data is valid.
- rd_val_data  output  16  payload word; the first received byte sits in [15:8].
- rd_done  output  1  one-cycle pulse at end of transaction (success or error).
- rd_err  output  2  0 = ok, 1 = R1 timeout, 2 = R1 nonzero, 3 = token timeout or data-error token. Held until the next accepted start.

Behaviour:
- Reset values: sd_clk=0, sd_cs=1, sd_mosi=1, rd_busy=0, rd_val_en=0, rd_val_data=0, rd_done=0, rd_err=0. State goes to IDLE and all counters clear. Reset asserted mid-transaction forces these values on the next clk_ref edge; no partial rd_done is issued.
- SPI timing is mode 0:
  - A divider counter runs only outside IDLE/DONE.
  - Every CLK_DIV cycles sd_clk toggles.
  - A rising toggle samples sd_miso (MSB first).
  - A falling toggle shifts the next sd_mosi bit.
  - Before the first rising edge, sd_mosi holds bit 47 of the command.
- Acceptance: rd_start is accepted only when state=IDLE and sd_init_done=1; otherwise it is ignored with no pulses. On acceptance, rd_sec_addr is latched, rd_busy rises the next cycle, and rd_err clears.
- State machine:
  - IDLE -> SEND_CMD on accept. sd_cs=0 from the SEND_CMD entry.
  - SEND_CMD: shift 48 bits {0x51, addr[31:0], 0xFF}, then go to WAIT_R1. sd_mosi=1 in all later states.
  - WAIT_R1: assemble bytes on 8-bit boundaries. The first byte with bit7=0 is R1.
    - R1=0x00 -> WAIT_TOKEN.
    - R1≠0x00 -> rd_err=2, go to TRAIL.
    - After R1_MAX_BYTES bytes all 0xFF -> rd_err=1, go to TRAIL.
  - WAIT_TOKEN: byte-aligned poll.
    - 0xFE -> READ_DATA.
    - 0xFF -> keep polling.
    - Any other byte -> rd_err=3, go to TRAIL.
    - TOKEN_MAX_BYTES bytes of 0xFF -> rd_err=3, go to TRAIL.
  - READ_DATA: 4096 bits. After each 16th sampled bit, rd_val_data takes the 16-bit shift value and rd_val_en pulses for exactly one clk_ref cycle. Exactly 256 strobes are issued; a 12-bit bit counter wraps to 0 at the end, then go to READ_CRC.
  - READ_CRC: 16 bits clocked and discarded; no strobes; then TRAIL.
  - TRAIL: sd_cs=1 and 8 further sd_clk cycles with sd_mosi=1, then DONE.
  - DONE: sd_clk=0, rd_done=1 for one cycle, rd_busy=0 in the same cycle, then IDLE.
- The next rd_start is accepted in the cycle after rd_done at the earliest.
- If sd_init_done drops mid-transaction, it is ignored; the transaction completes.
- rd_val_data holds its last value between strobes.

Test Plan:
- Nominal read: rd_sec_addr=0x0000_1234 with the card model returning R1=0x00 after 2 idle bytes, token 0xFE after 10 bytes, payload bytes i mod 256. Required response:
  - MOSI bits equal 0x51_00001234_FF.
  - Exactly 256 rd_val_en strobes; word 0=0x0001, word 255=0xFEFF.
  - rd_done pulses once and rd_err=0.
  - sd_cs returns high and is followed by 8 sd_clk cycles.
- R1 timeout: the card holds MISO=1 -> after 8 byte slots rd_err=1, rd_done pulses, and there are zero strobes.
- R1 error: the card returns R1=0x04 -> rd_err=2, zero strobes, sd_cs=1 before rd_done.
- Data-error token: R1=0x00, then byte 0x08 -> rd_err=3 and zero strobes. A follow-up clean read returns rd_err=0, confirming the error clears on restart.
- Gating:
  - rd_start with sd_init_done=0 -> no rd_busy and sd_cs stays 1.
  - rd_start while busy (mid READ_DATA) -> ignored; rd_sec_addr changes are not used.
- Reset mid-read: assert rst after strobe 100 -> on the next clk_ref edge sd_cs=1, sd_clk=0, rd_busy=0, and no rd_done. A fresh read afterwards yields 256 strobes.
